// File: rtl/alu_pkg.sv
// Shared types and default widths for the arbitrated ALU block.
// No logic; constants and enums only.
// Imported by the ALU core and the arbiter.
package alu_pkg;

    localparam int DEF_BITS = 32;
    localparam int DEF_OP_W = 3;

    typedef enum logic [DEF_OP_W-1:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_SETB = 3'd5,
        OP_CLRB = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/rdzen_alu.sv
// Combinational ALU core: add/sub with signed overflow, logic ops, bit set/clear.
// Latency: zero cycles, purely combinational.
// Backpressure: none; caller registers operands and result.
module rdzen_alu
    import alu_pkg::*;
#(
    parameter int BITS = DEF_BITS,
    parameter int OP_W = DEF_OP_W
) (
    input  logic [OP_W-1:0] op,
    input  logic [BITS-1:0] arg_a,
    input  logic [BITS-1:0] arg_b,
    output logic [BITS-1:0] result,
    output logic            error
);

    localparam int IDX_W = $clog2(BITS);
    localparam int MSB   = BITS - 1;
    localparam logic [BITS-1:0] ONE     = {{(BITS-1){1'b0}}, 1'b1};
    localparam logic [BITS-1:0] MAX_IDX = BITS'(BITS - 1);

    logic [BITS-1:0] sum;
    logic [BITS-1:0] diff;
    logic [BITS-1:0] mask;
    logic            bit_ok;

    // Evaluate the selected opcode; any error forces the result to zero.
    always_comb begin
        sum    = arg_a + arg_b;
        diff   = arg_a - arg_b;
        // A negative index is also caught by the unsigned range test, the
        // explicit sign check just makes the intent obvious.
        bit_ok = ~arg_b[MSB] && (arg_b <= MAX_IDX);
        mask   = ONE << arg_b[IDX_W-1:0];
        result = '0;
        error  = 1'b0;
        case (op)
            OP_ADD: begin
                if ((arg_a[MSB] == arg_b[MSB]) && (sum[MSB] != arg_a[MSB])) error = 1'b1;
                else result = sum;
            end
            OP_SUB: begin
                if ((arg_a[MSB] != arg_b[MSB]) && (diff[MSB] != arg_a[MSB])) error = 1'b1;
                else result = diff;
            end
            OP_AND: result = arg_a & arg_b;
            OP_OR:  result = arg_a | arg_b;
            OP_XOR: result = arg_a ^ arg_b;
            OP_SETB: begin
                if (bit_ok) result = arg_a | mask;
                else error = 1'b1;
            end
            OP_CLRB: begin
                if (bit_ok) result = arg_a & ~mask;
                else error = 1'b1;
            end
            default: error = 1'b1;
        endcase
    end

endmodule

// File: rtl/arbiter_alu.sv
// Round-robin arbiter and sequencer for two requesters sharing one ALU core.
// Latency: request handshake at edge N, response valid after edge N+1.
// Backpressure: response held while i_resp_ready=0; no request ready outside IDLE.
module arbiter_alu
    import alu_pkg::*;
#(
    parameter int BITS = DEF_BITS,
    parameter int OP_W = DEF_OP_W
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_req0_valid,
    output logic            o_req0_ready,
    input  logic [OP_W-1:0] i_req0_op,
    input  logic [BITS-1:0] i_req0_arg_A,
    input  logic [BITS-1:0] i_req0_arg_B,
    input  logic            i_req1_valid,
    output logic            o_req1_ready,
    input  logic [OP_W-1:0] i_req1_op,
    input  logic [BITS-1:0] i_req1_arg_A,
    input  logic [BITS-1:0] i_req1_arg_B,
    output logic            o_resp_valid,
    input  logic            i_resp_ready,
    output logic            o_resp_id,
    output logic [BITS-1:0] o_result,
    output logic            o_error
);

    state_e          state;
    logic            last_id;
    logic [OP_W-1:0] op_q;
    logic [BITS-1:0] a_q;
    logic [BITS-1:0] b_q;
    logic            id_q;

    logic [BITS-1:0] alu_result;
    logic            alu_error;
    logic            accept;

    rdzen_alu #(
        .BITS (BITS),
        .OP_W (OP_W)
    ) u_alu (
        .op     (op_q),
        .arg_a  (a_q),
        .arg_b  (b_q),
        .result (alu_result),
        .error  (alu_error)
    );

    // Grant: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        o_req0_ready = (state == ST_IDLE) && i_req0_valid && (!i_req1_valid || last_id);
        o_req1_ready = (state == ST_IDLE) && i_req1_valid && (!i_req0_valid || !last_id);
        accept       = o_req0_ready || o_req1_ready;
    end

    // Sequencer: latch operands on accept, capture the core output, hold until consumed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_IDLE;
            last_id      <= 1'b1;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            o_resp_valid <= 1'b0;
            o_resp_id    <= 1'b0;
            o_result     <= '0;
            o_error      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q    <= o_req1_ready ? i_req1_op    : i_req0_op;
                        a_q     <= o_req1_ready ? i_req1_arg_A : i_req0_arg_A;
                        b_q     <= o_req1_ready ? i_req1_arg_B : i_req0_arg_B;
                        id_q    <= o_req1_ready;
                        last_id <= o_req1_ready;
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    o_result     <= alu_result;
                    o_error      <= alu_error;
                    o_resp_id    <= id_q;
                    o_resp_valid <= 1'b1;
                    state        <= ST_RESP;
                end
                ST_RESP: begin
                    if (i_resp_ready) begin
                        o_resp_valid <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
